if_stage_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a decoupled prefetch queue. It replaces the single-register fetch stage and sits between the instruction memory and the ID stage. It issues sequential word fetches to a one-cycle-latency synchronous instruction memory and buffers returned instructions with their addresses in a FIFO of DEPTH entries. ID consumes them through a valid/ready handshake, and taken branches redirect fetch and squash all younger work.

---
 rtl/if_pkg.sv | 31 +++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/if_stage_prefetch.sv | 94 +++++++++
 tb/tb_if_stage_prefetch.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Purpose : shared fetch-stage types and the branch-target helper (also used by EX).
// Latency : n/a (types and pure functions only).
// Backpressure: n/a.
package if_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int IF_ADDR_W   = 32;
  localparam int IF_INSTR_W  = 32;

  // Default-width view of one prefetch entry, for blocks built at 32/32.
  typedef struct packed {
    logic [IF_ADDR_W-1:0]  pc;
    logic [IF_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sign-extend the low off_w bits of off to 64 bits.
  function automatic logic [63:0] sext_off(input logic [63:0] off, input int off_w);
    logic [63:0] sh;
    sh = off << (64 - off_w);
    return $signed(sh) >>> (64 - off_w);
  endfunction

  // target = pc + 4 + (sext(off) << 2), evaluated in 64 bits; the caller
  // truncates to its address width, so wrap-around is silent.
  function automatic logic [63:0] branch_target(input logic [63:0] pc,
                                                input logic [63:0] off,
                                                input int          off_w);
    return pc + 64'(INSTR_BYTES) + (sext_off(off, off_w) << 2);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Purpose : prefetch queue with synchronous push/pop/clear and a count output.
// Latency : a push is visible at the head the cycle after it lands; no bypass.
// Backpressure: none internally; the caller must never push when full or pop when empty.
// Ports   : clk/rst (async active-low), i_push/i_push_dat, i_pop, i_clr (wins
//           over push/pop), o_head_dat, o_count (0..DEPTH), o_vld (count != 0).
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  input  logic                     i_clr,
  output logic [WIDTH-1:0]         o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_vld
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (i_push && !i_clr) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_vld      = (r_count != '0);

endmodule

// File: rtl/if_stage_prefetch.sv
// Purpose : instruction fetch with a DEPTH-entry prefetch queue and branch redirect.
// Latency : fetch issued in cycle N is offered to ID in N+2; redirect at T shows target at T+3.
// Backpressure: out_ready low fills the queue; issue stops once count + inflight reaches DEPTH.
// Ports   : clk, rst (async active-low); imem_req/imem_addr/imem_rdata (1-cycle memory);
//           br_taken/br_pc/br_offset (redirect from EX); out_valid/out_ready/out_pc/out_instr (to ID).
module if_stage_prefetch
  import if_pkg::*;
#(
  parameter int               ADDR_W   = 32,
  parameter int               INSTR_W  = 32,
  parameter int               DEPTH    = 4,
  parameter int               OFF_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_pc,
  input  logic [OFF_W-1:0]   br_offset,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_pc,
  output logic [INSTR_W-1:0] out_instr
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_inflight;

  logic [ADDR_W-1:0] w_target;
  logic [CW-1:0]     w_count;
  logic              w_push;
  logic              w_pop;
  entry_t            w_push_dat;
  entry_t            w_head;

  assign w_target = ADDR_W'(branch_target(64'(br_pc), 64'(br_offset), OFF_W));

  // Reserving a slot for the in-flight word is what makes the push overflow-free.
  // rst gating keeps imem_req low for the whole reset window.
  assign imem_req  = rst && !br_taken && ((w_count + CW'(r_inflight)) < CW'(DEPTH));
  assign imem_addr = r_fetch_pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_pc <= RESET_PC;
      r_inflight    <= 1'b0;
    end else begin
      // imem_req is already low on a redirect, so the returning word is dropped.
      r_inflight <= imem_req;
      if (br_taken) begin
        r_fetch_pc <= w_target;
      end else if (imem_req) begin
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(INSTR_BYTES);
        r_inflight_pc <= r_fetch_pc;
      end
    end
  end

  // A redirect voids both the return and the ID handshake in its cycle.
  assign w_push     = r_inflight && !br_taken;
  assign w_pop      = out_valid && out_ready && !br_taken;
  assign w_push_dat = '{pc: r_inflight_pc, instr: imem_rdata};

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_clr      (br_taken),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_vld      (out_valid)
  );

  assign out_pc    = w_head.pc;
  assign out_instr = w_head.instr;

endmodule

// File: tb/tb_if_stage_prefetch.sv
module tb_if_stage_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        br_taken;
  logic [31:0] br_pc;
  logic [15:0] br_offset;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] pc;
    logic [15:0] off;
    logic [31:0] tgt;
  } br_vec_t;

  br_vec_t vecs[6];

  if_stage_prefetch #(
    .ADDR_W(32), .INSTR_W(32), .DEPTH(4), .OFF_W(16), .RESET_PC(32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .br_taken   (br_taken),
    .br_pc      (br_pc),
    .br_offset  (br_offset),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr)
  );

  always #5 clk = ~clk;

  // One-cycle synchronous memory: word at addr is addr>>2; garbage when not requested.
  always @(posedge clk) begin
    imem_rdata <= imem_req ? (imem_addr >> 2) : 32'hDEADBEEF;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Restart the expected ID stream at a new address.
  task automatic expect_from(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Scoreboard: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst && out_valid && out_ready && !br_taken) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pop", {32'h0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", {32'h0, out_pc}, {32'h0, e});
        chk("sb_instr", {32'h0, out_instr}, {32'h0, e >> 2});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prev_req;

    vecs[0] = '{pc: 32'h0000_0040, off: 16'd3,    tgt: 32'h0000_0050};
    vecs[1] = '{pc: 32'h0000_0010, off: 16'hFFFF, tgt: 32'h0000_0010};
    vecs[2] = '{pc: 32'hFFFF_FFFC, off: 16'd0,    tgt: 32'h0000_0000};
    vecs[3] = '{pc: 32'h0000_0100, off: 16'hFFFB, tgt: 32'h0000_00F0};
    vecs[4] = '{pc: 32'h0000_0000, off: 16'h7FFF, tgt: 32'h0002_0000};
    vecs[5] = '{pc: 32'h0002_0000, off: 16'h8000, tgt: 32'h0000_0004};

    rst = 1'b0; br_taken = 1'b0; br_pc = '0; br_offset = '0; out_ready = 1'b1;

    // Reset state
    sample(); sample();
    chk("rst_imem_req", {63'h0, imem_req}, 64'h0);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_imem_addr", {32'h0, imem_addr}, 64'h0);

    // Reset release: req in cycle 0, valid in cycle 2, then one per cycle
    expect_from(32'h0);
    tick(); rst = 1'b1;
    sample();
    chk("rel_c0_req", {63'h0, imem_req}, 64'h1);
    chk("rel_c0_addr", {32'h0, imem_addr}, 64'h0);
    tick(); sample();
    chk("rel_c1_valid", {63'h0, out_valid}, 64'h0);
    tick(); sample();
    chk("rel_c2_valid", {63'h0, out_valid}, 64'h1);
    chk("rel_c2_pc", {32'h0, out_pc}, 64'h0);
    for (int i = 0; i < 6; i++) begin
      tick(); sample();
      chk("stream_valid", {63'h0, out_valid}, 64'h1);
    end

    // Stall for 10 cycles: queue saturates and issue stops
    tick(); out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin tick(); end
    sample();
    chk("stall_req_off", {63'h0, imem_req}, 64'h0);
    chk("stall_valid", {63'h0, out_valid}, 64'h1);
    tick(); out_ready = 1'b1;
    sample();
    chk("drain_c0_req", {63'h0, imem_req}, 64'h0);
    tick(); sample();
    chk("drain_c1_req", {63'h0, imem_req}, 64'h1);
    for (int i = 0; i < 8; i++) begin
      tick(); sample();
      chk("drain_valid", {63'h0, out_valid}, 64'h1);
    end

    // Branch-target table: redirect timing and squash
    for (int v = 0; v < 6; v++) begin
      tick();
      br_taken = 1'b1; br_pc = vecs[v].pc; br_offset = vecs[v].off;
      expect_from(vecs[v].tgt);
      sample();
      chk("br_T_req", {63'h0, imem_req}, 64'h0);
      tick(); br_taken = 1'b0;
      sample();
      chk("br_T1_req", {63'h0, imem_req}, 64'h1);
      chk("br_T1_addr", {32'h0, imem_addr}, {32'h0, vecs[v].tgt});
      chk("br_T1_valid", {63'h0, out_valid}, 64'h0);
      tick(); sample();
      chk("br_T2_valid", {63'h0, out_valid}, 64'h0);
      tick(); sample();
      chk("br_T3_valid", {63'h0, out_valid}, 64'h1);
      chk("br_T3_pc", {32'h0, out_pc}, {32'h0, vecs[v].tgt});
      for (int i = 0; i < 3; i++) begin tick(); end
    end

    // Redirect coinciding with a handshake and an in-flight return
    sample();
    prev_req = imem_req;
    chk("corner_pre_req", {63'h0, prev_req}, 64'h1);
    tick();
    br_taken = 1'b1; br_pc = 32'h0000_01FC; br_offset = 16'd0;
    expect_from(32'h0000_0200);
    sample();
    chk("corner_T_valid", {63'h0, out_valid}, 64'h1);
    tick(); br_taken = 1'b0;
    sample();
    chk("corner_T1_empty", {63'h0, out_valid}, 64'h0);
    tick(); sample();
    chk("corner_T2_empty", {63'h0, out_valid}, 64'h0);
    tick(); sample();
    chk("corner_T3_pc", {32'h0, out_pc}, 64'h200);
    for (int i = 0; i < 3; i++) begin tick(); end

    // Reset mid-stream with three entries queued
    tick();
    br_taken = 1'b1; br_pc = 32'h0000_02FC; br_offset = 16'd0; out_ready = 1'b0;
    expect_from(32'h0000_0300);
    tick(); br_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin tick(); end
    sample();
    chk("mid_full_req", {63'h0, imem_req}, 64'h0);
    chk("mid_valid", {63'h0, out_valid}, 64'h1);
    chk("mid_head_pc", {32'h0, out_pc}, 64'h300);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {63'h0, out_valid}, 64'h0);
    chk("mid_rst_req", {63'h0, imem_req}, 64'h0);
    chk("mid_rst_addr", {32'h0, imem_addr}, 64'h0);
    tick(); tick();
    expect_from(32'h0);
    out_ready = 1'b1;
    rst = 1'b1;
    sample();
    chk("rerel_c0_req", {63'h0, imem_req}, 64'h1);
    chk("rerel_c0_addr", {32'h0, imem_addr}, 64'h0);
    tick(); sample();
    chk("rerel_c1_valid", {63'h0, out_valid}, 64'h0);
    tick(); sample();
    chk("rerel_c2_valid", {63'h0, out_valid}, 64'h1);
    chk("rerel_c2_pc", {32'h0, out_pc}, 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick(); sample();
      chk("rerel_stream", {63'h0, out_valid}, 64'h1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
